// File: rtl/dram_id_remap_pkg.sv
// Shared widths, AXI channel/request/response structs and the counter-width helper for dram_id_remap.
package dram_id_remap_pkg;

    localparam int DefSlvIdWidth   = 6;
    localparam int DefMstIdWidth   = 4;
    localparam int DefTableEntries = 8;
    localparam int DefMaxTxnsPerId = 8;
    localparam int AddrWidth       = 32;
    localparam int DataWidth       = 64;
    localparam int UserWidth       = 4;

    function automatic int cnt_width(input int max_txns);
        return $clog2(max_txns + 1);
    endfunction

    typedef struct packed {
        logic [DefSlvIdWidth-1:0] id;
        logic [AddrWidth-1:0]     addr;
        logic [7:0]               len;
        logic [2:0]               size;
        logic [1:0]               burst;
        logic [UserWidth-1:0]     user;
    } slv_ax_chan_t;

    typedef struct packed {
        logic [DefMstIdWidth-1:0] id;
        logic [AddrWidth-1:0]     addr;
        logic [7:0]               len;
        logic [2:0]               size;
        logic [1:0]               burst;
        logic [UserWidth-1:0]     user;
    } mst_ax_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0]   data;
        logic [DataWidth/8-1:0] strb;
        logic                   last;
        logic [UserWidth-1:0]   user;
    } w_chan_t;

    typedef struct packed {
        logic [DefSlvIdWidth-1:0] id;
        logic [1:0]               resp;
        logic [UserWidth-1:0]     user;
    } slv_b_chan_t;

    typedef struct packed {
        logic [DefMstIdWidth-1:0] id;
        logic [1:0]               resp;
        logic [UserWidth-1:0]     user;
    } mst_b_chan_t;

    typedef struct packed {
        logic [DefSlvIdWidth-1:0] id;
        logic [DataWidth-1:0]     data;
        logic [1:0]               resp;
        logic                     last;
        logic [UserWidth-1:0]     user;
    } slv_r_chan_t;

    typedef struct packed {
        logic [DefMstIdWidth-1:0] id;
        logic [DataWidth-1:0]     data;
        logic [1:0]               resp;
        logic                     last;
        logic [UserWidth-1:0]     user;
    } mst_r_chan_t;

    typedef struct packed {
        slv_ax_chan_t aw;
        logic         aw_valid;
        w_chan_t      w;
        logic         w_valid;
        logic         b_ready;
        slv_ax_chan_t ar;
        logic         ar_valid;
        logic         r_ready;
    } axi_slv_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        ar_ready;
        logic        w_ready;
        slv_b_chan_t b;
        logic        b_valid;
        slv_r_chan_t r;
        logic        r_valid;
    } axi_slv_rsp_t;

    typedef struct packed {
        mst_ax_chan_t aw;
        logic         aw_valid;
        w_chan_t      w;
        logic         w_valid;
        logic         b_ready;
        mst_ax_chan_t ar;
        logic         ar_valid;
        logic         r_ready;
    } axi_mst_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        ar_ready;
        logic        w_ready;
        mst_b_chan_t b;
        logic        b_valid;
        mst_r_chan_t r;
        logic        r_valid;
    } axi_mst_rsp_t;

endpackage

// File: rtl/dram_id_remap_table.sv
// One direction's remap table: SoC ID -> slot (controller ID) with per-slot outstanding counters.
module dram_id_remap_table
    import dram_id_remap_pkg::*;
#(
    parameter int SlvIdWidth   = DefSlvIdWidth,
    parameter int MstIdWidth   = DefMstIdWidth,
    parameter int TableEntries = DefTableEntries,
    parameter int MaxTxnsPerId = DefMaxTxnsPerId
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [SlvIdWidth-1:0] lookup_id,
    output logic [MstIdWidth-1:0] lookup_idx,
    output logic                  stall,
    input  logic                  push,
    input  logic                  resp_hs,
    input  logic                  resp_last,
    input  logic [MstIdWidth-1:0] resp_idx,
    output logic [SlvIdWidth-1:0] resp_id,
    output logic                  resp_err
);

    localparam int CntW = cnt_width(MaxTxnsPerId);

    logic [TableEntries-1:0] vld_q;
    logic [SlvIdWidth-1:0]   id_q  [TableEntries];
    logic [CntW-1:0]         cnt_q [TableEntries];

    logic                  hit, hit_full, free, resp_ok;
    logic [MstIdWidth-1:0] hit_idx, free_idx;
    logic [TableEntries-1:0] inc, dec;

    // Lookup sees only registered state, so a slot freed this cycle is not reused until the next one.
    always_comb begin
        hit      = 1'b0;
        hit_full = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        for (int i = TableEntries - 1; i >= 0; i--) begin
            if (vld_q[i] && id_q[i] == lookup_id) begin
                hit      = 1'b1;
                hit_idx  = MstIdWidth'(i);
                hit_full = (cnt_q[i] == CntW'(MaxTxnsPerId));
            end
            if (!vld_q[i]) begin
                free     = 1'b1;
                free_idx = MstIdWidth'(i);
            end
        end
        lookup_idx = hit ? hit_idx : free_idx;
        stall      = hit ? hit_full : !free;
    end

    always_comb begin
        resp_ok = 1'b0;
        resp_id = '0;
        for (int i = 0; i < TableEntries; i++) begin
            if (resp_idx == MstIdWidth'(i) && vld_q[i] && cnt_q[i] != '0) begin
                resp_ok = 1'b1;
                resp_id = id_q[i];
            end
        end
    end

    assign resp_err = resp_hs & !resp_ok;

    always_comb begin
        inc = '0;
        dec = '0;
        for (int i = 0; i < TableEntries; i++) begin
            inc[i] = push && lookup_idx == MstIdWidth'(i);
            dec[i] = resp_hs && resp_last && resp_ok && resp_idx == MstIdWidth'(i);
        end
    end

    // Push and pop on the same slot cancel out and the slot stays valid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            for (int i = 0; i < TableEntries; i++) begin
                id_q[i]  <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < TableEntries; i++) begin
                if (inc[i] && !dec[i]) begin
                    vld_q[i] <= 1'b1;
                    id_q[i]  <= lookup_id;
                    cnt_q[i] <= cnt_q[i] + CntW'(1);
                end else if (dec[i] && !inc[i]) begin
                    cnt_q[i] <= cnt_q[i] - CntW'(1);
                    if (cnt_q[i] == CntW'(1)) vld_q[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/dram_id_remap.sv
// AXI ID remapper in front of a narrow-ID DRAM controller; sticky err_o exists with DRAM_ID_REMAP_ERR_EN.
module dram_id_remap
    import dram_id_remap_pkg::*;
#(
    parameter int  SlvIdWidth   = DefSlvIdWidth,
    parameter int  MstIdWidth   = DefMstIdWidth,
    parameter int  TableEntries = DefTableEntries,
    parameter int  MaxTxnsPerId = DefMaxTxnsPerId,
    parameter type slv_req_t    = axi_slv_req_t,
    parameter type slv_rsp_t    = axi_slv_rsp_t,
    parameter type mst_req_t    = axi_mst_req_t,
    parameter type mst_rsp_t    = axi_mst_rsp_t
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  slv_req_t slv_req_i,
    output slv_rsp_t slv_rsp_o,
    output mst_req_t mst_req_o,
    input  mst_rsp_t mst_rsp_i
`ifdef DRAM_ID_REMAP_ERR_EN
    ,
    output logic     err_o
`endif
);

    logic                  aw_stall, ar_stall, aw_push, ar_push, b_hs, r_hs, b_err, r_err;
    logic [MstIdWidth-1:0] aw_idx, ar_idx;
    logic [SlvIdWidth-1:0] b_id, r_id;

    // A transfer happens when valid and ready are both high at a rising edge; stall gates valid and
    // ready together and depends only on table state and the request ID, never on a ready.
    assign aw_push = slv_req_i.aw_valid & !aw_stall & mst_rsp_i.aw_ready;
    assign ar_push = slv_req_i.ar_valid & !ar_stall & mst_rsp_i.ar_ready;
    assign b_hs    = mst_rsp_i.b_valid & slv_req_i.b_ready;
    assign r_hs    = mst_rsp_i.r_valid & slv_req_i.r_ready;

    dram_id_remap_table #(
        .SlvIdWidth(SlvIdWidth), .MstIdWidth(MstIdWidth),
        .TableEntries(TableEntries), .MaxTxnsPerId(MaxTxnsPerId)
    ) u_wr_table (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .lookup_id(slv_req_i.aw.id), .lookup_idx(aw_idx), .stall(aw_stall), .push(aw_push),
        .resp_hs(b_hs), .resp_last(1'b1), .resp_idx(mst_rsp_i.b.id),
        .resp_id(b_id), .resp_err(b_err)
    );

    dram_id_remap_table #(
        .SlvIdWidth(SlvIdWidth), .MstIdWidth(MstIdWidth),
        .TableEntries(TableEntries), .MaxTxnsPerId(MaxTxnsPerId)
    ) u_rd_table (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .lookup_id(slv_req_i.ar.id), .lookup_idx(ar_idx), .stall(ar_stall), .push(ar_push),
        .resp_hs(r_hs), .resp_last(mst_rsp_i.r.last), .resp_idx(mst_rsp_i.r.id),
        .resp_id(r_id), .resp_err(r_err)
    );

    always_comb begin
        mst_req_o.aw.id    = aw_idx;
        mst_req_o.aw.addr  = slv_req_i.aw.addr;
        mst_req_o.aw.len   = slv_req_i.aw.len;
        mst_req_o.aw.size  = slv_req_i.aw.size;
        mst_req_o.aw.burst = slv_req_i.aw.burst;
        mst_req_o.aw.user  = slv_req_i.aw.user;
        mst_req_o.aw_valid = slv_req_i.aw_valid & !aw_stall;
        mst_req_o.w        = slv_req_i.w;
        mst_req_o.w_valid  = slv_req_i.w_valid;
        mst_req_o.b_ready  = slv_req_i.b_ready;
        mst_req_o.ar.id    = ar_idx;
        mst_req_o.ar.addr  = slv_req_i.ar.addr;
        mst_req_o.ar.len   = slv_req_i.ar.len;
        mst_req_o.ar.size  = slv_req_i.ar.size;
        mst_req_o.ar.burst = slv_req_i.ar.burst;
        mst_req_o.ar.user  = slv_req_i.ar.user;
        mst_req_o.ar_valid = slv_req_i.ar_valid & !ar_stall;
        mst_req_o.r_ready  = slv_req_i.r_ready;

        slv_rsp_o.aw_ready = mst_rsp_i.aw_ready & !aw_stall;
        slv_rsp_o.ar_ready = mst_rsp_i.ar_ready & !ar_stall;
        slv_rsp_o.w_ready  = mst_rsp_i.w_ready;
        slv_rsp_o.b.id     = b_id;
        slv_rsp_o.b.resp   = mst_rsp_i.b.resp;
        slv_rsp_o.b.user   = mst_rsp_i.b.user;
        slv_rsp_o.b_valid  = mst_rsp_i.b_valid;
        slv_rsp_o.r.id     = r_id;
        slv_rsp_o.r.data   = mst_rsp_i.r.data;
        slv_rsp_o.r.resp   = mst_rsp_i.r.resp;
        slv_rsp_o.r.last   = mst_rsp_i.r.last;
        slv_rsp_o.r.user   = mst_rsp_i.r.user;
        slv_rsp_o.r_valid  = mst_rsp_i.r_valid;
    end

`ifdef DRAM_ID_REMAP_ERR_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)             err_o <= 1'b0;
        else if (b_err || r_err) err_o <= 1'b1;
    end
`else
    logic unused_err;
    assign unused_err = b_err | r_err;
`endif

endmodule

// File: tb/tb_dram_id_remap.sv
// Directed bench for dram_id_remap: queue-based outstanding-transaction model plus literal checks.
module tb_dram_id_remap;
    import dram_id_remap_pkg::*;

    typedef struct {
        logic [5:0] soc;
        logic [3:0] mst;
    } txn_t;

    logic         clk = 1'b0;
    logic         rst_n;
    axi_slv_req_t slv_req;
    axi_slv_rsp_t slv_rsp;
    axi_mst_req_t mst_req;
    axi_mst_rsp_t mst_rsp;
`ifdef DRAM_ID_REMAP_ERR_EN
    logic         err;
`endif

    int   n_checks = 0;
    int   n_pass   = 0;
    txn_t wr_q[$];
    txn_t rd_q[$];
    bit   err_exp = 1'b0;

    always #5 clk = ~clk;

    dram_id_remap dut (
        .clk_i(clk), .rst_ni(rst_n),
        .slv_req_i(slv_req), .slv_rsp_o(slv_rsp),
        .mst_req_o(mst_req), .mst_rsp_i(mst_rsp)
`ifdef DRAM_ID_REMAP_ERR_EN
        , .err_o(err)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Outstanding transactions are a flat list of (SoC id, controller id) pairs.
    function automatic void model_lookup(input bit dir, input logic [5:0] soc,
                                         output bit stall, output logic [3:0] idx);
        txn_t q[$];
        bit   used[8];
        int   same = 0;
        q   = dir ? rd_q : wr_q;
        idx = '0;
        for (int m = 0; m < 8; m++) used[m] = 1'b0;
        foreach (q[k]) begin
            used[q[k].mst[2:0]] = 1'b1;
            if (q[k].soc == soc) begin
                same++;
                idx = q[k].mst;
            end
        end
        if (same > 0) stall = (same >= 8);
        else begin
            stall = 1'b1;
            for (int m = 7; m >= 0; m--) if (!used[m]) begin stall = 1'b0; idx = 4'(m); end
        end
    endfunction

    function automatic logic [6:0] model_resp(input bit dir, input logic [3:0] m);
        txn_t q[$];
        q = dir ? rd_q : wr_q;
        foreach (q[k]) if (q[k].mst == m) return {1'b1, q[k].soc};
        return 7'd0;
    endfunction

    function automatic void model_pop(input bit dir, input logic [3:0] m);
        int pos = -1;
        if (dir) begin
            for (int k = 0; k < rd_q.size(); k++) if (pos < 0 && rd_q[k].mst == m) pos = k;
            if (pos >= 0) rd_q.delete(pos);
        end else begin
            for (int k = 0; k < wr_q.size(); k++) if (pos < 0 && wr_q[k].mst == m) pos = k;
            if (pos >= 0) wr_q.delete(pos);
        end
    endfunction

    bit         aw_st, ar_st;
    logic [3:0] aw_ix, ar_ix;
    logic [6:0] b_exp, r_exp;
    txn_t       t;

    always @(negedge clk) begin
        if (!rst_n) begin
            wr_q.delete();
            rd_q.delete();
            err_exp = 1'b0;
        end
        model_lookup(1'b0, slv_req.aw.id, aw_st, aw_ix);
        model_lookup(1'b1, slv_req.ar.id, ar_st, ar_ix);
        b_exp = model_resp(1'b0, mst_rsp.b.id);
        r_exp = model_resp(1'b1, mst_rsp.r.id);
        check("aw_valid", 32'(mst_req.aw_valid), 32'(slv_req.aw_valid & !aw_st));
        check("aw_ready", 32'(slv_rsp.aw_ready), 32'(mst_rsp.aw_ready & !aw_st));
        check("ar_valid", 32'(mst_req.ar_valid), 32'(slv_req.ar_valid & !ar_st));
        check("ar_ready", 32'(slv_rsp.ar_ready), 32'(mst_rsp.ar_ready & !ar_st));
        if (mst_req.aw_valid) begin
            check("aw_id", 32'(mst_req.aw.id), 32'(aw_ix));
            check("aw_addr", mst_req.aw.addr, slv_req.aw.addr);
        end
        if (mst_req.ar_valid) check("ar_id", 32'(mst_req.ar.id), 32'(ar_ix));
        if (mst_rsp.b_valid) check("b_id", 32'(slv_rsp.b.id), 32'(b_exp[5:0]));
        if (mst_rsp.r_valid) begin
            check("r_id", 32'(slv_rsp.r.id), 32'(r_exp[5:0]));
            check("r_data", slv_rsp.r.data[31:0], mst_rsp.r.data[31:0]);
        end
        if (slv_req.w_valid) check("w_data", mst_req.w.data[31:0], slv_req.w.data[31:0]);
`ifdef DRAM_ID_REMAP_ERR_EN
        check("err", 32'(err), 32'(err_exp));
`endif
        if (rst_n) begin
            if (mst_rsp.b_valid && slv_req.b_ready) begin
                if (b_exp[6]) model_pop(1'b0, mst_rsp.b.id);
                else err_exp = 1'b1;
            end
            if (mst_rsp.r_valid && slv_req.r_ready) begin
                if (!r_exp[6]) err_exp = 1'b1;
                else if (mst_rsp.r.last) model_pop(1'b1, mst_rsp.r.id);
            end
            if (slv_req.aw_valid && !aw_st && mst_rsp.aw_ready) begin
                t.soc = slv_req.aw.id; t.mst = aw_ix; wr_q.push_back(t);
            end
            if (slv_req.ar_valid && !ar_st && mst_rsp.ar_ready) begin
                t.soc = slv_req.ar.id; t.mst = ar_ix; rd_q.push_back(t);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        slv_req.aw_valid = 1'b0;
        slv_req.ar_valid = 1'b0;
        slv_req.w_valid  = 1'b0;
        mst_rsp.b_valid  = 1'b0;
        mst_rsp.r_valid  = 1'b0;
    endtask

    task automatic set_aw(input logic [5:0] id);
        slv_req.aw_valid = 1'b1;
        slv_req.aw.id    = id;
        slv_req.aw.addr  = $urandom;
        slv_req.aw.len   = 8'($urandom_range(0, 15));
        slv_req.w_valid  = 1'b1;
        slv_req.w.data   = {$urandom, $urandom};
    endtask

    task automatic set_ar(input logic [5:0] id);
        slv_req.ar_valid = 1'b1;
        slv_req.ar.id    = id;
        slv_req.ar.addr  = $urandom;
    endtask

    task automatic set_b(input logic [3:0] id);
        mst_rsp.b_valid = 1'b1;
        mst_rsp.b.id    = id;
        mst_rsp.b.resp  = 2'($urandom_range(0, 3));
    endtask

    task automatic set_r(input logic [3:0] id, input logic last);
        mst_rsp.r_valid = 1'b1;
        mst_rsp.r.id    = id;
        mst_rsp.r.last  = last;
        mst_rsp.r.data  = {$urandom, $urandom};
    endtask

    task automatic aw_lit(input logic [5:0] id, input int exp_idx);
        set_aw(id);
        @(negedge clk);
        check("lit_aw_ready", 32'(slv_rsp.aw_ready), 1);
        check("lit_aw_id", 32'(mst_req.aw.id), exp_idx);
        step();
        idle();
    endtask

    task automatic ar_lit(input logic [5:0] id, input int exp_idx);
        set_ar(id);
        @(negedge clk);
        check("lit_ar_ready", 32'(slv_rsp.ar_ready), 1);
        check("lit_ar_id", 32'(mst_req.ar.id), exp_idx);
        step();
        idle();
    endtask

    task automatic b_lit(input logic [3:0] id, input int exp_soc);
        set_b(id);
        @(negedge clk);
        check("lit_b_id", 32'(slv_rsp.b.id), exp_soc);
        step();
        idle();
    endtask

    task automatic r_lit(input logic [3:0] id, input logic last, input int exp_soc);
        set_r(id, last);
        @(negedge clk);
        check("lit_r_id", 32'(slv_rsp.r.id), exp_soc);
        step();
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        slv_req = '0;
        mst_rsp = '0;
        slv_req.b_ready  = 1'b1;
        slv_req.r_ready  = 1'b1;
        mst_rsp.aw_ready = 1'b1;
        mst_rsp.ar_ready = 1'b1;
        mst_rsp.w_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_aw_valid", 32'(mst_req.aw_valid), 0);
        check("rst_b_valid", 32'(slv_rsp.b_valid), 0);
        step();

        // Single write, then the freed slot 0 is reused the following cycle.
        aw_lit(6'h2A, 0);
        b_lit(4'd0, 'h2A);
        aw_lit(6'h33, 0);
        b_lit(4'd0, 'h33);

        // Same-ID reuse on the read side.
        ar_lit(6'h05, 0);
        ar_lit(6'h05, 0);
        ar_lit(6'h05, 0);
        ar_lit(6'h11, 1);
        r_lit(4'd0, 1'b0, 'h05);
        r_lit(4'd0, 1'b1, 'h05);
        r_lit(4'd1, 1'b1, 'h11);
        r_lit(4'd0, 1'b1, 'h05);
        ar_lit(6'h22, 1);
        r_lit(4'd0, 1'b1, 'h05);
        ar_lit(6'h23, 0);
        r_lit(4'd1, 1'b1, 'h22);
        r_lit(4'd0, 1'b1, 'h23);

        // Write table full; the ninth ID waits for a B, then takes the freed slot.
        for (int i = 0; i < 8; i++) aw_lit(6'(8'h30 + i), i);
        set_aw(6'h38);
        @(negedge clk);
        check("full_aw_ready", 32'(slv_rsp.aw_ready), 0);
        check("full_aw_valid", 32'(mst_req.aw_valid), 0);
        step();
        step();
        set_b(4'd5);
        @(negedge clk);
        check("full_pop_aw_ready", 32'(slv_rsp.aw_ready), 0);
        check("full_pop_b_id", 32'(slv_rsp.b.id), 'h35);
        step();
        mst_rsp.b_valid = 1'b0;
        @(negedge clk);
        check("full_retry_aw_ready", 32'(slv_rsp.aw_ready), 1);
        check("full_retry_aw_id", 32'(mst_req.aw.id), 5);
        step();
        idle();
        for (int i = 0; i < 8; i++) b_lit(4'(i), (i == 5) ? 'h38 : 'h30 + i);

        // Counter saturation on one read ID.
        for (int i = 0; i < 8; i++) ar_lit(6'h07, 0);
        set_ar(6'h07);
        @(negedge clk);
        check("sat_ar_ready", 32'(slv_rsp.ar_ready), 0);
        step();
        set_r(4'd0, 1'b1);
        @(negedge clk);
        check("sat_pop_ar_ready", 32'(slv_rsp.ar_ready), 0);
        step();
        mst_rsp.r_valid = 1'b0;
        @(negedge clk);
        check("sat_retry_ar_ready", 32'(slv_rsp.ar_ready), 1);
        check("sat_retry_ar_id", 32'(mst_req.ar.id), 0);
        step();
        idle();
        r_lit(4'd0, 1'b0, 'h07);
        for (int i = 0; i < 8; i++) r_lit(4'd0, 1'b1, 'h07);

        // Simultaneous push/pop on slot 2, then a slot freed this cycle is skipped.
        ar_lit(6'h01, 0);
        ar_lit(6'h02, 1);
        ar_lit(6'h03, 2);
        set_ar(6'h03);
        set_r(4'd2, 1'b1);
        @(negedge clk);
        check("simul_ar_id", 32'(mst_req.ar.id), 2);
        check("simul_r_id", 32'(slv_rsp.r.id), 'h03);
        step();
        idle();
        r_lit(4'd2, 1'b1, 'h03);
        set_ar(6'h2C);
        set_r(4'd0, 1'b1);
        @(negedge clk);
        check("freed_ar_id", 32'(mst_req.ar.id), 2);
        check("freed_r_id", 32'(slv_rsp.r.id), 'h01);
        step();
        idle();
        r_lit(4'd1, 1'b1, 'h02);
        r_lit(4'd2, 1'b1, 'h2C);

        // Asynchronous reset in the middle of a read burst drops all tracking.
        ar_lit(6'h09, 0);
        ar_lit(6'h0A, 1);
        r_lit(4'd0, 1'b0, 'h09);
        #2 rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        ar_lit(6'h0A, 0);
        r_lit(4'd0, 1'b1, 'h0A);

        // Response to an empty slot.
        b_lit(4'd3, 0);
`ifdef DRAM_ID_REMAP_ERR_EN
        @(negedge clk);
        check("err_set", 32'(err), 1);
        step();
        step();
        @(negedge clk);
        check("err_sticky", 32'(err), 1);
        #1 rst_n = 1'b0;
        #1 check("err_reset", 32'(err), 0);
        step();
        rst_n = 1'b1;
`endif
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
